dense_layer_engine: RTL and testbench
=====================================

Name: dense_layer_engine

Overview:
Parametrised fully-connected layer for the DQN forward path: N_IN inputs, N_OUT neurons, signed fixed-point.
- Streams one input activation per handshake into N_OUT parallel MAC accumulators.
- Adds bias, requantises with saturation and applies a selectable activation.
- Streams results out one neuron per handshake.
- Holds its own weight/bias register file, written directly or updated by saturating delta-add (backprop update path).
- Instantiated once per layer: hidden (9->5) and output (5->4).

Parameters:
N_IN, 9, inputs per vector
N_OUT, 5, neurons
DW, 16, data/weight/bias width, signed two's complement
FRAC, 10, fractional bits (Q5.10 at defaults)
ACT, 1, activation: 0 identity, 1 ReLU, 2 leaky ReLU (negative x -> x>>>3)

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts input beat
in_data  in  DW  input activation x_i, i = beat order 0..N_IN-1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DW  activated result a_j
out_idx  out  clog2(N_OUT)  neuron index j of out_data
out_last  out  1  high with j = N_OUT-1
wr_en  in  1  parameter write strobe
wr_mode  in  1  0 overwrite, 1 saturating add (delta)
wr_addr  in  clog2(N_IN*N_OUT+N_OUT)  parameter address
wr_data  in  DW  value or delta
wr_err  out  1  one-cycle pulse: write dropped (engine busy)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst and clk as decided, synchronous, active-high. On rst: state IDLE; accumulators, input counter, result registers, all weights and biases = 0; out_valid=0, out_data=0, out_idx=0, out_last=0, wr_err=0, busy=0, in_ready=1 from the first post-reset cycle. Reset mid-operation aborts the vector; no partial output is emitted.
- Address map: addr < N_IN*N_OUT -> w[i][j], with addr = i*N_OUT + j. addr N_IN*N_OUT + j -> b[j]. Higher addresses are ignored, with no error.
- Writes are accepted only in IDLE. In any other state the write is dropped and wr_err pulses the next cycle.
- wr_mode=1 adds and saturates to [-2^(DW-1), 2^(DW-1)-1].
- FSM IDLE: in_ready=1. On in_valid, x_0 is accumulated and the FSM moves to ACCUM, or straight to ACT when N_IN=1. A write in the same cycle as the first beat is honoured; the MAC uses the pre-write value.
- FSM ACCUM: in_ready=1. Each beat does acc[j] += x_i * w[i][j] for all j in parallel and increments i. On beat N_IN-1 the FSM moves to ACT.
- FSM ACT: exactly one cycle, in_ready=0.
  - For each j: s = (acc[j] + (b[j] <<< FRAC)) >>> FRAC. The shift is arithmetic and truncates toward -inf.
  - s is saturated to DW bits, then passed through the activation.
  - The result is latched into res[j]. Accumulators are cleared. FSM moves to OUT.
- FSM OUT: out_valid=1, in_ready=0, out_idx=k, out_data=res[k], starting at k=0.
  - k advances only on out_valid & out_ready.
  - out_data, out_idx and out_last are stable while stalled.
  - The handshake at k=N_OUT-1 returns the FSM to IDLE, with out_valid=0 the next cycle.
- Latency: last input beat accepted at cycle t -> out_valid=1 at t+2.
- Back-to-back vectors: a new vector starts in the cycle after the final output handshake. No overlap.
- Accumulator width: 2*DW + clog2(N_IN) + 1. The bias-aligned add cannot overflow the accumulator.
- in_valid is ignored while in_ready=0. out_ready is ignored while out_valid=0.

Decomposition:
- Shared package dqn_pkg holds:
  - ACT_* encoding constants.
  - Function sat_dw(value, width).
  - Function act_fn(mode, x).
  - Address-map helper for weight/bias index.
- One natural sub-module, dle_param_rf: weight/bias register file with overwrite and saturating delta-add write, exposing a full row w[i][*] combinationally.
- The engine top holds the FSM, MACs, requantiser and output serialiser.

Test Plan:
- Defaults, all w=1024, all b=0, nine inputs of 512 -> five outputs of 4608, out_idx 0..4, out_last on idx 4, out_valid at t+2.
- All w=-1024, b[2]=1024, inputs 512: ACT=1 -> idx2=0 and others=0. ACT=2 -> idx2=-448 and others=-576. ACT=0 -> idx2=-3584 and others=-4608.
- All w=32767, inputs 32767 -> every output 32767. All w=-32768, inputs 32767, ACT=0 -> every output -32768.
- Backpressure: out_ready low for 3 cycles at idx1 -> out_data/out_idx held constant, no skipped or duplicated index. in_valid asserted during OUT -> ignored.
- Delta write:
  - w[0][0]=1024 then mode 1 delta 512 -> 1536.
  - b[0]=32000 plus delta 32767 -> 32767.
  - A write during ACCUM -> wr_err pulse and the value is unchanged.
- rst after 4 input beats -> next cycle in_ready=1, out_valid=0, weights zero. After reloading params, a full vector reproduces the first scenario exactly.

Source files
------------

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN forward-path engines: activation codes, FSM states,
// saturation/activation helpers and the weight/bias address map.
package dqn_pkg;

  localparam int unsigned ACT_IDENT = 0;
  localparam int unsigned ACT_RELU  = 1;
  localparam int unsigned ACT_LEAKY = 2;

  typedef enum logic [1:0] {StIdle, StAccum, StAct, StOut} dle_state_e;

  // Clamp a signed value into the range of a 'width'-bit two's complement number.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] value,
                                                input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic logic signed [63:0] act_fn(input int unsigned mode,
                                                input logic signed [63:0] x);
    if (mode == ACT_RELU && x < 0) return '0;
    if (mode == ACT_LEAKY && x < 0) return x >>> 3;
    return x;
  endfunction

  function automatic int unsigned w_addr(input int unsigned i, input int unsigned j,
                                         input int unsigned n_out);
    return i * n_out + j;
  endfunction

  function automatic int unsigned b_addr(input int unsigned j, input int unsigned n_in,
                                         input int unsigned n_out);
    return n_in * n_out + j;
  endfunction

endpackage

// File: rtl/dle_param_rf.sv
// Weight/bias register file: overwrite or saturating delta-add writes, with one weight
// row w[row][*] and all biases readable combinationally.
module dle_param_rf
  import dqn_pkg::*;
#(
  parameter int unsigned N_IN  = 9,
  parameter int unsigned N_OUT = 5,
  parameter int unsigned DW    = 16,
  localparam int unsigned AW   = $clog2(N_IN * N_OUT + N_OUT),
  localparam int unsigned RW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_mode,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [RW-1:0] row,
  output logic [DW-1:0] row_w [N_OUT],
  output logic [DW-1:0] bias  [N_OUT]
);

  localparam int unsigned NP = N_IN * N_OUT + N_OUT;
  localparam logic [AW:0] NP_L = (AW + 1)'(NP);

  logic [DW-1:0] mem_q [NP];
  logic [DW-1:0] old_val;
  logic [DW-1:0] wr_val;
  logic          in_range;

  assign in_range = {1'b0, wr_addr} < NP_L;
  assign old_val  = mem_q[wr_addr];

  always_comb begin
    wr_val = wr_data;
    if (wr_mode) begin
      wr_val = DW'(sat_dw({{(64 - DW){old_val[DW-1]}}, old_val} +
                          {{(64 - DW){wr_data[DW-1]}}, wr_data}, DW));
    end
  end

  // Out-of-map addresses are silently ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en && in_range) begin
      mem_q[wr_addr] <= wr_val;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_OUT; j++) begin
      row_w[j] = mem_q[AW'(w_addr(32'(row), j, N_OUT))];
      bias[j]  = mem_q[AW'(b_addr(j, N_IN, N_OUT))];
    end
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer: streams N_IN activations into N_OUT parallel MACs, adds bias,
// requantises with saturation, applies the activation and streams N_OUT results out.
module dense_layer_engine
  import dqn_pkg::*;
#(
  parameter int unsigned N_IN  = 9,
  parameter int unsigned N_OUT = 5,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACT   = 1,
  localparam int unsigned IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned AW   = $clog2(N_IN * N_OUT + N_OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  input  logic          wr_en,
  input  logic          wr_mode,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  output logic          busy
);

  localparam int unsigned CW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ACCW = 2 * DW + $clog2(N_IN) + 1;

  dle_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic                  wr_err_q;
  logic signed [ACCW-1:0] acc_q [N_OUT];
  logic signed [ACCW-1:0] mac   [N_OUT];
  logic [DW-1:0]         res_q   [N_OUT];
  logic [DW-1:0]         res_nxt [N_OUT];
  logic [DW-1:0]         row_w   [N_OUT];
  logic [DW-1:0]         bias    [N_OUT];
  logic                  last_beat;
  logic                  idx_last;

  // Parameter writes land only while idle; the MAC reads the pre-write row this cycle.
  dle_param_rf #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .DW    (DW)
  ) u_param_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && (state_q == StIdle)),
    .wr_mode (wr_mode),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .row     (cnt_q),
    .row_w   (row_w),
    .bias    (bias)
  );

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] bias_al;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] shr;
    logic signed [63:0]     s64;

    assign prod    = $signed(in_data) * $signed(row_w[j]);
    assign mac[j]  = acc_q[j] + {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
    assign bias_al = {{(ACCW - DW){bias[j][DW-1]}}, bias[j]} <<< FRAC;
    assign sum     = acc_q[j] + bias_al;
    // Arithmetic shift floors toward -inf.
    assign shr     = sum >>> FRAC;
    assign s64     = {{(64 - ACCW){shr[ACCW-1]}}, shr};
    assign res_nxt[j] = DW'(act_fn(ACT, sat_dw(s64, DW)));
  end

  assign last_beat = (cnt_q == CW'(N_IN - 1));
  assign idx_last  = (idx_q == IW'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_err_q <= 1'b0;
      acc_q    <= '{default: '0};
      res_q    <= '{default: '0};
    end else begin
      wr_err_q <= wr_en && (state_q != StIdle);
      unique case (state_q)
        StIdle, StAccum: begin
          if (in_valid) begin
            acc_q <= mac;
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StAct;
            end else begin
              cnt_q   <= cnt_q + CW'(1);
              state_q <= StAccum;
            end
          end
        end
        StAct: begin
          res_q   <= res_nxt;
          acc_q   <= '{default: '0};
          idx_q   <= '0;
          state_q <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign out_idx   = idx_q;
  assign out_data  = res_q[idx_q];
  assign out_last  = out_valid && idx_last;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench: three engines (identity, ReLU, leaky) share stimulus and are
// compared against a table of known results and an arithmetic reference model.
module tb_dense_layer_engine;

  localparam int N_IN = 9;
  localparam int N_OUT = 5;
  localparam int NW = N_IN * N_OUT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_mode = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] wr_data = '0;
  logic [5:0]  wr_addr = '0;

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_last  [3];
  logic        wr_err    [3];
  logic        busy      [3];
  logic [15:0] out_data  [3];
  logic [2:0]  out_idx   [3];

  always #5 clk = ~clk;

  for (genvar a = 0; a < 3; a++) begin : g_dut
    dense_layer_engine #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .DW    (16),
      .FRAC  (10),
      .ACT   (a)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[a]),
      .in_data   (in_data),
      .out_valid (out_valid[a]),
      .out_ready (out_ready),
      .out_data  (out_data[a]),
      .out_idx   (out_idx[a]),
      .out_last  (out_last[a]),
      .wr_en     (wr_en),
      .wr_mode   (wr_mode),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_err    (wr_err[a]),
      .busy      (busy[a])
    );
  end

  int checks = 0;
  int passes = 0;
  int mw [N_IN][N_OUT];
  int mb [N_OUT];
  int ex [3][N_OUT];

  typedef struct {
    int wv; int bv; int b2; int xv;
    int eo0; int eo1; int eo2;
    int e20; int e21; int e22;
  } tv_t;
  tv_t tbl [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_out(input int act, input int j, input int x [N_IN]);
    longint acc;
    longint s;
    acc = longint'(mb[j]) * 1024;
    for (int i = 0; i < N_IN; i++) acc += longint'(x[i]) * longint'(mw[i][j]);
    s = sat16(fdiv(acc, 1024));
    if (act == 1 && s < 0) s = 0;
    if (act == 2 && s < 0) s = fdiv(s, 8);
    return int'(s);
  endfunction

  function automatic void model_write(input int mode, input int addr, input int data);
    int old;
    int nv;
    if (addr >= NW + N_OUT) return;
    old = (addr < NW) ? mw[addr / N_OUT][addr % N_OUT] : mb[addr - NW];
    nv = (mode != 0) ? int'(sat16(longint'(old) + longint'(data))) : data;
    if (addr < NW) mw[addr / N_OUT][addr % N_OUT] = nv;
    else mb[addr - NW] = nv;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N_IN; i++) for (int j = 0; j < N_OUT; j++) mw[i][j] = 0;
    for (int j = 0; j < N_OUT; j++) mb[j] = 0;
  endfunction

  function automatic void set_model_exp(input int x [N_IN]);
    for (int a = 0; a < 3; a++) for (int j = 0; j < N_OUT; j++) ex[a][j] = model_out(a, j, x);
  endfunction

  function automatic int rnd(input int full);
    if (full != 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic wr(input int mode, input int addr, input int data);
    wr_en = 1'b1; wr_mode = mode[0]; wr_addr = addr[5:0]; wr_data = data[15:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(mode, addr, data);
  endtask

  task automatic load_uniform(input int wv, input int bv, input int b2);
    for (int a = 0; a < NW; a++) wr(0, a, wv);
    for (int j = 0; j < N_OUT; j++) wr(0, NW + j, (j == 2) ? b2 : bv);
  endtask

  task automatic feed(input int x [N_IN], input int wbeat, input int waddr, input int wdata);
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data = x[i][15:0];
      if (i == wbeat) begin
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = waddr[5:0]; wr_data = wdata[15:0];
      end
      chk($sformatf("in_ready beat%0d", i), in_ready[0], 1);
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (wbeat > 0 && i == wbeat) chk("wr_err pulse", wr_err[0], 1);
      if (wbeat > 0 && i == wbeat + 1) chk("wr_err clear", wr_err[0], 0);
      if (wbeat == 0 && i == 0) chk("wr_err idle write", wr_err[0], 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_k, input int stall_n, input bit poke);
    int cyc;
    chk("out_valid at t+1", out_valid[0], 0);
    out_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      cyc = 0;
      while (!out_valid[0] && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (k == 0) chk("latency to out_valid", cyc, 1);
      if (!out_valid[0]) begin
        chk("out_valid timeout", 0, 1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        return;
      end
      in_valid = poke && (k < N_OUT - 1);
      in_data = 16'h4000;
      if (poke) chk("in_ready during out", in_ready[0], 0);
      for (int a = 0; a < 3; a++) begin
        chk($sformatf("out_data act%0d k%0d", a, k), $signed(out_data[a]), ex[a][k]);
        chk($sformatf("out_idx act%0d", a), out_idx[a], k);
        chk($sformatf("out_last act%0d k%0d", a, k), out_last[a], (k == N_OUT - 1) ? 1 : 0);
      end
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          chk("stall out_valid", out_valid[0], 1);
          chk("stall out_data", $signed(out_data[0]), ex[0][k]);
          chk("stall out_idx", out_idx[0], k);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("out_valid after last", out_valid[0], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

  initial begin
    int x [N_IN];
    int xz [N_IN];
    int wd;

    tbl[0] = '{1024, 0, 0, 512, 4608, 4608, 4608, 4608, 4608, 4608};
    tbl[1] = '{-1024, 0, 1024, 512, -4608, 0, -576, -3584, 0, -448};
    tbl[2] = '{32767, 0, 0, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    tbl[3] = '{-32768, 0, 0, 32767, -32768, 0, -4096, -32768, 0, -4096};
    for (int i = 0; i < N_IN; i++) xz[i] = 0;

    do_reset();
    chk("reset in_ready", in_ready[0], 1);
    chk("reset out_valid", out_valid[0], 0);
    chk("reset busy", busy[0], 0);
    chk("reset wr_err", wr_err[0], 0);
    chk("reset out_data", out_data[0], 0);
    chk("reset out_idx", out_idx[0], 0);
    chk("reset out_last", out_last[0], 0);

    // Table vectors; the first also stalls at idx1 and pokes in_valid during OUT.
    for (int t = 0; t < 4; t++) begin
      load_uniform(tbl[t].wv, tbl[t].bv, tbl[t].b2);
      for (int j = 0; j < N_OUT; j++) begin
        ex[0][j] = (j == 2) ? tbl[t].e20 : tbl[t].eo0;
        ex[1][j] = (j == 2) ? tbl[t].e21 : tbl[t].eo1;
        ex[2][j] = (j == 2) ? tbl[t].e22 : tbl[t].eo2;
      end
      for (int i = 0; i < N_IN; i++) x[i] = tbl[t].xv;
      feed(x, -1, 0, 0);
      chk("busy after vector in", busy[0], 1);
      collect((t == 0) ? 1 : -1, 3, t == 0);
    end

    // Delta writes: 1024 + 512 on w[0][0], then bias saturation.
    do_reset();
    wr(0, 0, 1024);
    wr(1, 0, 512);
    for (int i = 0; i < N_IN; i++) x[i] = 0;
    x[0] = 1024;
    for (int a = 0; a < 3; a++) for (int j = 0; j < N_OUT; j++) ex[a][j] = (j == 0) ? 1536 : 0;
    feed(x, -1, 0, 0);
    collect(-1, 0, 0);
    wr(0, NW, 32000);
    wr(1, NW, 32767);
    for (int a = 0; a < 3; a++) for (int j = 0; j < N_OUT; j++) ex[a][j] = (j == 0) ? 32767 : 0;
    feed(xz, -1, 0, 0);
    collect(-1, 0, 0);

    // Write to b[1] during ACCUM is dropped.
    feed(xz, 3, NW + 1, 5000);
    collect(-1, 0, 0);

    // Reset after four beats aborts the vector and clears parameters.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'd512;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk("mid reset in_ready", in_ready[0], 1);
    chk("mid reset out_valid", out_valid[0], 0);
    chk("mid reset busy", busy[0], 0);
    for (int i = 0; i < N_IN; i++) x[i] = 512;
    for (int a = 0; a < 3; a++) for (int j = 0; j < N_OUT; j++) ex[a][j] = 0;
    feed(x, -1, 0, 0);
    collect(-1, 0, 0);
    load_uniform(1024, 0, 0);
    for (int a = 0; a < 3; a++) for (int j = 0; j < N_OUT; j++) ex[a][j] = 4608;
    feed(x, -1, 0, 0);
    collect(-1, 0, 0);

    // Randomised parameters and inputs against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < NW + N_OUT; a++) wr(int'($urandom_range(0, 1)), a, rnd(r % 2));
      wr(0, NW + N_OUT + int'($urandom_range(0, 8)), rnd(1));
      for (int i = 0; i < N_IN; i++) x[i] = rnd(r % 2);
      set_model_exp(x);
      if (r == 4) begin
        // Write on the first beat: honoured, but this vector uses the old weight.
        wd = rnd(1);
        x[0] = (x[0] == 0) ? 100 : x[0];
        set_model_exp(x);
        feed(x, 0, 0, wd);
        model_write(0, 0, wd);
      end else begin
        feed(x, -1, 0, 0);
      end
      collect((r == 5) ? int'($urandom_range(0, N_OUT - 1)) : -1, 2, r == 3);
    end
    for (int i = 0; i < N_IN; i++) x[i] = rnd(0);
    set_model_exp(x);
    feed(x, -1, 0, 0);
    collect(-1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
